// File: rtl/mod_exp_ctrl_if.sv
// Pulse-handshake bus between the exponentiation sequencer and an external
// interleaved modular multiplier.
interface mod_exp_ctrl_if #(
  parameter int NBITS = 4096
);
  logic             mul_start_p;
  logic [NBITS-1:0] mul_a;
  logic [NBITS-1:0] mul_b;
  logic [NBITS-1:0] mul_m;
  logic [NBITS-1:0] mul_y;
  logic             mul_done_p;

  // Sequencer side issues requests; multiplier side returns the product.
  modport master (
    output mul_start_p, mul_a, mul_b, mul_m,
    input  mul_y, mul_done_p
  );

  modport slave (
    input  mul_start_p, mul_a, mul_b, mul_m,
    output mul_y, mul_done_p
  );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Modular exponentiation sequencer: left-to-right binary square-and-multiply,
// delegating every product to an external modular multiplier.
module mod_exp_ctrl #(
  parameter int NBITS = 4096,
  parameter int EBITS = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic [NBITS-1:0] base,
  input  logic [EBITS-1:0] exp,
  input  logic [NBITS-1:0] m,
  output logic [NBITS-1:0] result,
  output logic             busy,
  output logic             done_irq_p,
  mod_exp_ctrl_if.master   mul
);

  localparam int IW = (EBITS > 1) ? $clog2(EBITS) : 1;

  typedef enum logic [2:0] {
    IDLE, SCAN, SQR, SQR_WAIT, MUL, MUL_WAIT, DONE
  } state_t;

  state_t           state;
  logic [NBITS-1:0] r;
  logic [NBITS-1:0] base_r;
  logic [EBITS-1:0] exp_r;
  logic [NBITS-1:0] m_r;
  logic [IW-1:0]    idx;

  assign mul.mul_m = m_r;

  // NOTE: every register is cleared by the async reset so an abort leaves no
  // stale operands behind; all state updates use non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      r               <= '0;
      base_r          <= '0;
      exp_r           <= '0;
      m_r             <= '0;
      idx             <= '0;
      result          <= '0;
      busy            <= 1'b0;
      done_irq_p      <= 1'b0;
      mul.mul_start_p <= 1'b0;
      mul.mul_a       <= '0;
      mul.mul_b       <= '0;
    end else begin
      // NOTE: pulse outputs default low each cycle, so a state sets them for
      // exactly one clock without a separate clearing branch.
      mul.mul_start_p <= 1'b0;
      done_irq_p      <= 1'b0;

      unique case (state)
        IDLE: begin
          busy <= start_p;
          if (start_p) begin
            base_r <= base;
            exp_r  <= exp;
            m_r    <= m;
            r      <= NBITS'(1);
            idx    <= IW'(EBITS - 1);
            state  <= SCAN;
          end
        end

        // Skip leading zeros; the first one bit seeds the accumulator with base.
        SCAN: begin
          if (exp_r[idx]) begin
            r <= base_r;
            if (idx == '0) begin
              state <= DONE;
            end else begin
              idx   <= idx - 1'b1;
              state <= SQR;
            end
          end else if (idx == '0) begin
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end

        SQR: begin
          mul.mul_start_p <= 1'b1;
          mul.mul_a       <= r;
          mul.mul_b       <= r;
          state           <= SQR_WAIT;
        end

        SQR_WAIT: begin
          if (mul.mul_done_p) begin
            r <= mul.mul_y;
            if (exp_r[idx]) begin
              state <= MUL;
            end else if (idx == '0) begin
              state <= DONE;
            end else begin
              idx   <= idx - 1'b1;
              state <= SQR;
            end
          end
        end

        MUL: begin
          mul.mul_start_p <= 1'b1;
          mul.mul_a       <= r;
          mul.mul_b       <= base_r;
          state           <= MUL_WAIT;
        end

        MUL_WAIT: begin
          if (mul.mul_done_p) begin
            r <= mul.mul_y;
            if (idx == '0) begin
              state <= DONE;
            end else begin
              idx   <= idx - 1'b1;
              state <= SQR;
            end
          end
        end

        // busy stays high through the following IDLE cycle, where done_irq_p shows.
        DONE: begin
          result     <= r;
          done_irq_p <= 1'b1;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
- Modular exponentiation sequencer: computes result = base^exp mod m using left-to-right binary square-and-multiply.
- Acts as the initiator side of the mod-mul start/done pulse handshake. It issues each multiplication to an external interleaved modular multiplier and consumes that multiplier's result and done pulse.
- Sits above the multiplier in the RSA/exponentiation datapath. It owns no arithmetic of its own beyond operand muxing.

Parameters:
- NBITS, 4096, width of base, modulus, result and multiplier operands
- EBITS, 4096, width of exponent

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start_p  input  1  one-cycle start pulse; base/exp/m sampled on this cycle
- base  input  NBITS  base operand; requirement base < m
- exp  input  EBITS  exponent
- m  input  NBITS  modulus; requirement m > 1
- result  output  NBITS  last completed base^exp mod m
- busy  output  1  high from cycle after start_p accept until done_irq_p cycle inclusive
- done_irq_p  output  1  one-cycle completion pulse; result valid from this cycle
- mul_start_p  output  1  one-cycle request pulse to multiplier
- mul_a  output  NBITS  multiplier operand A
- mul_b  output  NBITS  multiplier operand B
- mul_m  output  NBITS  multiplier modulus (latched m)
- mul_y  input  NBITS  multiplier product
- mul_done_p  input  1  one-cycle multiplier completion pulse

Behaviour:
- Reset: state IDLE; result, mul_a, mul_b, mul_m, internal R, base_r, exp_r = 0; busy, done_irq_p, mul_start_p = 0. Asynchronous reset mid-operation aborts immediately. No pulse is emitted afterward, and a late mul_done_p is ignored.
- Registers:
  - R (NBITS) is the running accumulator.
  - i (clog2(EBITS) bits) is the bit index.
  - base_r, exp_r and m_r hold the latched operands.
  - mul_m = m_r, driven continuously.
- Operand hold: mul_a and mul_b are registered. They are stable from the mul_start_p cycle until mul_done_p.
- States:
  - IDLE:
    - On start_p: latch base, exp, m; R <= 1; i <= EBITS-1; go to SCAN.
    - start_p in any other state is ignored.
  - SCAN (leading-zero skip, one bit per cycle, no multiplication):
    - exp_r[i] == 0: if i == 0, go to DONE (result 1); else i <= i-1.
    - exp_r[i] == 1: R <= base_r; if i == 0, go to DONE; else i <= i-1 and go to SQR.
  - SQR: assert mul_start_p for one cycle with mul_a = mul_b = R; go to SQR_WAIT.
  - SQR_WAIT: on mul_done_p, R <= mul_y.
    - If exp_r[i], go to MUL.
    - Else if i == 0, go to DONE.
    - Else i <= i-1 and go to SQR.
  - MUL: assert mul_start_p for one cycle with mul_a = R, mul_b = base_r; go to MUL_WAIT.
  - MUL_WAIT: on mul_done_p, R <= mul_y.
    - If i == 0, go to DONE.
    - Else i <= i-1 and go to SQR.
  - DONE: result <= R; done_irq_p = 1 for exactly this cycle; busy deasserts the next cycle; go to IDLE.
- mul_done_p outside SQR_WAIT/MUL_WAIT is ignored. mul_done_p in the same cycle as mul_start_p cannot occur; the minimum multiplier latency is 1 cycle.
- Multiplication count: with p = index of the MSB one of exp, there are p squarings and popcount(exp)-1 multiplies.
- exp == 0: result = 1 with no multiplier requests (valid because m > 1).
- Wait states have no timeout; they wait indefinitely for mul_done_p.
- result holds its value between operations and is never cleared except by reset.
- A new start_p is accepted in the cycle after DONE (IDLE).

Test Plan:
- NBITS=EBITS=8, m=13, base=2, exp=10; responder model with random 1–20 cycle latency -> result=10, exactly 4 mul_start_p pulses (3 SQR, 1 MUL), one done_irq_p, busy drops the cycle after.
- exp=0, base=5, m=13 -> result=1, zero mul_start_p, done_irq_p 2+EBITS cycles after start_p (8 SCAN cycles).
- exp=1, base=7, m=13 -> result=7, zero mul_start_p.
- m=251, base=3, exp=255, real mod-mul instance connected -> result=243, 14 mul_start_p pulses; mul_a/mul_b stable throughout every wait.
- start_p re-pulsed mid-operation and a spurious mul_done_p in SCAN -> both ignored; result unchanged from the first case.
- rst_n low during SQR_WAIT, then a late mul_done_p -> all outputs 0, state IDLE, no done_irq_p; a following start_p computes correctly.
